// File: rtl/write_back_pkg.sv
// Shared types for the write-back stage: condition codes, flags, the
// memory-stage Signals bundle, the stage state enum and the condition helper.
package Common;

  localparam int FLUSH_DEPTH_DEFAULT = 3;
  localparam int REG_ADDR_W          = 5;

  typedef enum logic {
    RUN,
    SQUASH
  } WbState;

  typedef enum logic [2:0] {
    Never    = 3'd0,
    Always   = 3'd1,
    Zero     = 3'd2,
    NotZero  = 3'd3,
    Carry    = 3'd4,
    NotCarry = 3'd5
  } Cond;

  typedef struct packed {
    logic zero;
    logic carry;
  } Flags;

  // wdata[32] is the set-flags bit; wdata[31:0] is the result / branch target.
  typedef struct packed {
    logic                  wback;
    logic [REG_ADDR_W-1:0] wreg;
    logic                  branch;
    Flags                  flags;
    Cond                   cond;
    logic [32:0]           wdata;
  } Signals;

  function automatic logic eval_cond(input Cond c, input Flags f);
    logic r;
    r = 1'b0;
    case (c)
      Never:    r = 1'b0;
      Always:   r = 1'b1;
      Zero:     r = f.zero;
      NotZero:  r = ~f.zero;
      Carry:    r = f.carry;
      NotCarry: r = ~f.carry;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/write_back_reg_file.sv
// Architectural register file: one write port, two combinational read ports.
// r0 and addresses beyond NUM_REGS read as zero; r0 is never written.
module reg_file #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [31:0]       rdata1,
  output logic [31:0]       rdata2
);

  logic [31:0] mem [NUM_REGS];

  // Storage update; cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0) && (int'(waddr) < NUM_REGS)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port 1 with r0 / out-of-range forced to zero.
  always_comb begin
    rdata1 = '0;
    if ((raddr1 != '0) && (int'(raddr1) < NUM_REGS)) rdata1 = mem[raddr1];
  end

  // Read port 2 with r0 / out-of-range forced to zero.
  always_comb begin
    rdata2 = '0;
    if ((raddr2 != '0) && (int'(raddr2) < NUM_REGS)) rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: conditional commit of register/flag updates, registered
// branch redirect, and a fixed-length squash of wrong-path instructions.
// Optional macro WB_RETIRE_COUNTER_EN enables the o_retired commit counter;
// without it o_retired is tied to zero.
//
// state  | meaning
// RUN    | instructions evaluated and committed normally
// SQUASH | cnt remaining wrong-path inputs are discarded
module write_back
  import Common::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  Signals                      i_signals,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs2,
  output logic [31:0]                 o_rs1_data,
  output logic [31:0]                 o_rs2_data,
  output Flags                        o_flags,
  output logic                        o_redirect,
  output logic [31:0]                 o_target,
  output logic                        o_squashing,
  output logic [31:0]                 o_retired
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(FLUSH_DEPTH + 2);

  WbState           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  Flags             flags_q;
  logic             commit, taken, we, hit1, hit2;
  logic [31:0]      rf_rd1, rf_rd2;

  assign commit = (state_q == RUN) && eval_cond(i_signals.cond, flags_q);
  assign taken  = commit && i_signals.branch;
  assign we     = commit && i_signals.wback && (i_signals.wreg != '0)
                  && (int'(i_signals.wreg) < NUM_REGS);
  assign hit1   = we && (int'(i_signals.wreg) == int'(i_rs1));
  assign hit2   = we && (int'(i_signals.wreg) == int'(i_rs2));

  reg_file #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (ADDR_W'(i_signals.wreg)),
    .wdata  (i_signals.wdata[31:0]),
    .raddr1 (i_rs1),
    .raddr2 (i_rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // Read ports with same-cycle bypass of the committing write.
  always_comb begin
    o_rs1_data = rf_rd1;
    o_rs2_data = rf_rd2;
    if (i_rs1 == '0) o_rs1_data = '0;
    else if (hit1)   o_rs1_data = i_signals.wdata[31:0];
    if (i_rs2 == '0) o_rs2_data = '0;
    else if (hit2)   o_rs2_data = i_signals.wdata[31:0];
  end

  // Next-state logic: enter SQUASH on a taken branch, leave when cnt==1 is consumed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (taken && (FLUSH_DEPTH > 0)) begin
          state_d = SQUASH;
          cnt_d   = CNT_W'(FLUSH_DEPTH);
        end
      end
      SQUASH: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State and squash counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Architectural flags and registered redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= '0;
      o_redirect <= 1'b0;
      o_target   <= '0;
    end else begin
      if (commit && i_signals.wdata[32]) flags_q <= i_signals.flags;
      o_redirect <= taken;
      if (taken) o_target <= i_signals.wdata[31:0];
    end
  end

  assign o_flags     = flags_q;
  assign o_squashing = (state_q == SQUASH);

`ifdef WB_RETIRE_COUNTER_EN
  logic [31:0] retired_q;
  logic        is_bubble;

  assign is_bubble = !i_signals.wback && !i_signals.branch && !i_signals.wdata[32];

  // Count committed, non-bubble instructions; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else if (commit && (i_signals.cond != Never) && !is_bubble) retired_q <= retired_q + 32'd1;
  end

  assign o_retired = retired_q;
`else
  assign o_retired = '0;
`endif

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back with default parameters (16 regs, flush depth 3).
module tb_write_back;
  import Common::*;

`ifdef WB_RETIRE_COUNTER_EN
  localparam bit RET = 1'b1;
`else
  localparam bit RET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  Signals      sig;
  logic [3:0]  rs1, rs2;
  logic [31:0] d1, d2, target, retired;
  Flags        flags;
  logic        redirect, squashing;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  write_back dut (
    .clk         (clk),
    .rst         (rst),
    .i_signals   (sig),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .o_rs1_data  (d1),
    .o_rs2_data  (d2),
    .o_flags     (flags),
    .o_redirect  (redirect),
    .o_target    (target),
    .o_squashing (squashing),
    .o_retired   (retired)
  );

  function automatic Signals mk(input Cond c, input logic wb, input logic [4:0] wr,
                                input logic br, input logic sf, input Flags f,
                                input logic [31:0] d);
    Signals s;
    s.cond   = c;
    s.wback  = wb;
    s.wreg   = wr;
    s.branch = br;
    s.flags  = f;
    s.wdata  = {sf, d};
    return s;
  endfunction

  function automatic logic [31:0] ret_exp(input int n);
    return RET ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input Signals s, input logic [3:0] a1, input logic [3:0] a2);
    @(negedge clk);
    sig = s;
    rs1 = a1;
    rs2 = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  Signals bub;

  initial begin
    bub = mk(Never, 1'b0, 5'd0, 1'b0, 1'b0, '0, 32'd0);
    rst = 1'b1;
    sig = bub;
    rs1 = 4'd3;
    rs2 = 4'd0;
    #1;
    chk("reset_flags",    {31'd0, flags}, 33'd0);
    chk("reset_redirect", redirect, 1'b0);
    chk("reset_target",   target, 32'd0);
    chk("reset_squash",   squashing, 1'b0);
    chk("reset_retired",  retired, 32'd0);
    chk("reset_rf3",      d1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // conditional write with bypass
    drive(mk(Always, 1'b1, 5'd3, 1'b0, 1'b0, '0, 32'hDEADBEEF), 4'd3, 4'd3);
    chk("w3_bypass1", d1, 32'hDEADBEEF);
    chk("w3_bypass2", d2, 32'hDEADBEEF);
    tick();
    drive(bub, 4'd3, 4'd0);
    chk("w3_rf", d1, 32'hDEADBEEF);
    chk("w3_retired", retired, ret_exp(1));

    // r0 write dropped
    drive(mk(Always, 1'b1, 5'd0, 1'b0, 1'b0, '0, 32'h5), 4'd0, 4'd3);
    chk("r0_same", d1, 32'd0);
    chk("r0_rf3_keep", d2, 32'hDEADBEEF);
    tick();
    drive(bub, 4'd0, 4'd3);
    chk("r0_next", d1, 32'd0);

    // flags and conditions
    drive(mk(Always, 1'b0, 5'd0, 1'b0, 1'b1, Flags'(2'b10), 32'd0), 4'd2, 4'd0);
    tick();
    chk("flags_set", {31'd0, flags}, 33'b10);
    drive(mk(NotZero, 1'b1, 5'd2, 1'b0, 1'b0, '0, 32'd7), 4'd2, 4'd0);
    chk("nz_bypass", d1, 32'd0);
    tick();
    chk("nz_flags", {31'd0, flags}, 33'b10);
    drive(bub, 4'd2, 4'd0);
    chk("nz_rf2", d1, 32'd0);
    drive(mk(Zero, 1'b1, 5'd2, 1'b0, 1'b0, '0, 32'd7), 4'd2, 4'd0);
    chk("z_bypass", d1, 32'd7);
    tick();
    drive(bub, 4'd2, 4'd0);
    chk("z_rf2", d1, 32'd7);
    drive(mk(Carry, 1'b1, 5'd4, 1'b0, 1'b0, '0, 32'h11), 4'd4, 4'd0);
    chk("c_bypass", d1, 32'd0);
    drive(mk(NotCarry, 1'b1, 5'd4, 1'b0, 1'b0, '0, 32'h22), 4'd4, 4'd0);
    chk("nc_bypass", d1, 32'h22);
    tick();
    drive(bub, 4'd4, 4'd0);
    chk("nc_rf4", d1, 32'h22);
    chk("retired5", retired, ret_exp(5));

    // taken branch and squash of three wrong-path writes
    drive(mk(Always, 1'b0, 5'd0, 1'b1, 1'b0, '0, 32'h400), 4'd5, 4'd0);
    chk("br_pre_redirect", redirect, 1'b0);
    tick();
    chk("br_redirect", redirect, 1'b1);
    chk("br_target",   target, 32'h400);
    chk("br_squash",   squashing, 1'b1);
    drive(mk(Always, 1'b1, 5'd5, 1'b0, 1'b0, '0, 32'd1), 4'd5, 4'd0);
    chk("sq1_bypass", d1, 32'd0);
    tick();
    chk("sq1_redirect", redirect, 1'b0);
    chk("sq1_squash",   squashing, 1'b1);
    drive(mk(Always, 1'b1, 5'd5, 1'b0, 1'b0, '0, 32'd2), 4'd5, 4'd0);
    tick();
    chk("sq2_squash", squashing, 1'b1);
    drive(mk(Always, 1'b1, 5'd5, 1'b0, 1'b0, '0, 32'd3), 4'd5, 4'd0);
    chk("sq3_squash", squashing, 1'b1);
    tick();
    chk("sq_end", squashing, 1'b0);
    drive(bub, 4'd5, 4'd0);
    chk("rf5_clean", d1, 32'd0);
    drive(mk(Always, 1'b1, 5'd5, 1'b0, 1'b0, '0, 32'd9), 4'd5, 4'd0);
    chk("w9_bypass", d1, 32'd9);
    tick();
    drive(bub, 4'd5, 4'd0);
    chk("rf5_final", d1, 32'd9);
    chk("retired7", retired, ret_exp(7));

    // back-to-back branches, then reset one cycle into the squash
    drive(mk(Always, 1'b0, 5'd0, 1'b1, 1'b1, Flags'(2'b01), 32'h500), 4'd0, 4'd0);
    tick();
    chk("b2b_redirect", redirect, 1'b1);
    chk("b2b_target",   target, 32'h500);
    chk("b2b_flags",    {31'd0, flags}, 33'b01);
    drive(mk(Always, 1'b0, 5'd0, 1'b1, 1'b0, '0, 32'h800), 4'd0, 4'd0);
    tick();
    chk("b2b2_redirect", redirect, 1'b0);
    chk("b2b2_target",   target, 32'h500);
    chk("b2b2_squash",   squashing, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_squash",  squashing, 1'b0);
    chk("rst_flags",   {31'd0, flags}, 33'd0);
    chk("rst_target",  target, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sig = mk(Always, 1'b1, 5'd6, 1'b0, 1'b0, '0, 32'h66);
    rs1 = 4'd6;
    rs2 = 4'd5;
    #1;
    chk("post_bypass", d1, 32'h66);
    chk("post_rf5",    d2, 32'd0);
    tick();
    chk("post_redirect", redirect, 1'b0);
    drive(bub, 4'd6, 4'd0);
    chk("post_rf6",     d1, 32'h66);
    chk("post_retired", retired, ret_exp(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
